// File: rtl/pwm_axil_slave_if.sv
// pwm_axil_slave_if
//   AXI4-Lite bus bundle between the lite master and the PWM register slave.
//   Signal names keep the S_AXI_* naming of the IP's S00_AXI port.
//   Ports (via modports):
//     slave  : receives AW/W/AR channels and B/R ready, drives the ready
//              signals of AW/W/AR plus the B and R channels.
//     master : the mirror image, used by a bus master or a bench.
interface pwm_axil_slave_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/pwm_axil_slave.sv
// pwm_axil_slave
//   AXI4-Lite slave holding four 32-bit registers and a PWM generator.
//   Register map (only address bits [3:2] decoded, others alias):
//     0x0 CTRL    bit0 EN, bit1 POL
//     0x4 PERIOD  period length minus one
//     0x8 DUTY    number of active cycles per period
//     0xC SCRATCH free read/write storage
//   Ports:
//     S_AXI_ACLK    clock
//     S_AXI_ARESETN asynchronous active-low reset
//     s_axi         AXI4-Lite slave bundle (AW, W, B, AR, R channels)
//     pwm_out       registered PWM waveform
module pwm_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic            S_AXI_ACLK,
  input  logic            S_AXI_ARESETN,
  pwm_axil_slave_if.slave s_axi,
  output logic            pwm_out
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  // Register file and write-channel state
  logic [DW-1:0] regs_reg [4];
  logic          aw_cap_reg;
  logic          w_cap_reg;
  logic [1:0]    aw_idx_reg;
  logic [DW-1:0] w_data_reg;
  logic [SW-1:0] w_strb_reg;
  logic          awready_reg;
  logic          wready_reg;
  logic          bvalid_reg;

  // Read-channel state
  logic          arready_reg;
  logic          rvalid_reg;
  logic [DW-1:0] rdata_reg;

  // PWM engine state
  logic          en_d_reg;
  logic [DW-1:0] cnt_reg;
  logic [DW-1:0] per_s_reg;
  logic [DW-1:0] duty_s_reg;
  logic          pwm_reg;

  // Write channel next-state
  logic aw_hs, w_hs, commit;
  logic aw_cap_next, w_cap_next, bvalid_next, awready_next, wready_next;
  // Read channel next-state
  logic ar_hs, rvalid_next, arready_next;
  // PWM next-state
  logic          en, pol, load;
  logic [DW-1:0] cnt_next, per_s_next, duty_s_next;
  logic          pwm_next;

  logic [DW-1:0] wmask;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

  // Expand byte strobes into a bit mask for the read-modify-write merge.
  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_wmask
      assign wmask[8*gi +: 8] = {8{w_strb_reg[gi]}};
    end
  endgenerate

  always_comb begin
    aw_hs  = s_axi.S_AXI_AWVALID & awready_reg;
    w_hs   = s_axi.S_AXI_WVALID & wready_reg;
    // Both halves of the write are held: apply it on this edge.
    commit = aw_cap_reg & w_cap_reg;

    aw_cap_next  = commit ? 1'b0 : (aw_cap_reg | aw_hs);
    w_cap_next   = commit ? 1'b0 : (w_cap_reg | w_hs);
    bvalid_next  = commit | (bvalid_reg & ~s_axi.S_AXI_BREADY);
    // Readies are registered so they stay low through reset and rise on
    // the first edge after release.
    awready_next = ~aw_cap_next & ~bvalid_next;
    wready_next  = ~w_cap_next & ~bvalid_next;

    ar_hs        = s_axi.S_AXI_ARVALID & arready_reg;
    rvalid_next  = ar_hs | (rvalid_reg & ~s_axi.S_AXI_RREADY);
    arready_next = ~rvalid_next;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_cap_reg  <= 1'b0;
      w_cap_reg   <= 1'b0;
      aw_idx_reg  <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      aw_cap_reg  <= aw_cap_next;
      w_cap_reg   <= w_cap_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      if (aw_hs) begin
        aw_idx_reg <= s_axi.S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_data_reg <= s_axi.S_AXI_WDATA;
        w_strb_reg <= s_axi.S_AXI_WSTRB;
      end
      if (commit) begin
        regs_reg[aw_idx_reg] <= (regs_reg[aw_idx_reg] & ~wmask) | (w_data_reg & wmask);
      end
    end
  end

  // Read path samples the register file before any same-edge write lands.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
      if (ar_hs) begin
        rdata_reg <= regs_reg[s_axi.S_AXI_ARADDR[3:2]];
      end
    end
  end

  always_comb begin
    en   = regs_reg[0][0];
    pol  = regs_reg[0][1];
    // Shadows reload when the engine is switched on and at every period end,
    // so register writes only take effect on a period boundary.
    load = en & (~en_d_reg | (cnt_reg == per_s_reg));

    per_s_next  = load ? regs_reg[1] : per_s_reg;
    duty_s_next = load ? regs_reg[2] : duty_s_reg;
    cnt_next    = (!en || load) ? '0 : cnt_reg + 1'b1;
    // pwm_out is registered alongside the counter value it describes.
    pwm_next    = en ? ((cnt_next < duty_s_next) ^ pol) : pol;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      en_d_reg   <= 1'b0;
      cnt_reg    <= '0;
      per_s_reg  <= '0;
      duty_s_reg <= '0;
      pwm_reg    <= 1'b0;
    end else begin
      en_d_reg   <= en;
      cnt_reg    <= cnt_next;
      per_s_reg  <= per_s_next;
      duty_s_reg <= duty_s_next;
      pwm_reg    <= pwm_next;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_reg;
  assign s_axi.S_AXI_WREADY  = wready_reg;
  assign s_axi.S_AXI_BVALID  = bvalid_reg;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_reg;
  assign s_axi.S_AXI_RVALID  = rvalid_reg;
  assign s_axi.S_AXI_RDATA   = rdata_reg;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign pwm_out             = pwm_reg;
endmodule
